// File: rtl/ifetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests and buffers returns in a DEPTH-entry queue.
// Optional IFQ_BYPASS_EN: a response that fills the empty head is presented to decode in the same cycle.
module ifetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h80000000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       if_ready,
  output logic                       if_valid,
  output logic [31:0]                if_instr,
  output logic [31:0]                if_ia,
  output logic [31:0]                if_pc4,
  output logic [$clog2(DEPTH):0]     ifq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1) + 1;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [31:0]   ia_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];

  logic [OW:0]   inflight;
  logic [PW-1:0] fill_idx;
  logic          head_ready, rsp_fill, rsp_drop, rsp_any, byp, push, pop, wr_fill;

  // Filled entries are the oldest (cnt - outst) slots; pending ones sit just behind the tail.
  assign inflight   = {1'b0, outst_q} + {1'b0, drop_q};
  assign fill_idx   = tail_q - PW'(outst_q);
  assign head_ready = cnt_q != CW'(outst_q);
  assign rsp_any    = imem_rvalid && (inflight != '0);
  assign rsp_fill   = imem_rvalid && (drop_q == '0) && (outst_q != '0) && !redirect;
  assign rsp_drop   = imem_rvalid && (drop_q != '0);

`ifdef IFQ_BYPASS_EN
  assign byp = rsp_fill && !head_ready;
`else
  assign byp = 1'b0;
`endif

  assign imem_req  = !reset && !redirect && (cnt_q < CW'(DEPTH)) &&
                     (inflight < (OW + 1)'(MAX_OUTST));
  assign imem_addr = pc_q;
  assign if_valid  = !reset && !redirect && (head_ready || byp);
  assign if_ia     = if_valid ? ia_q[head_q] : 32'd0;
  assign if_instr  = !if_valid ? 32'd0 : (byp ? imem_rdata : instr_q[head_q]);
  assign if_pc4    = if_valid ? pc_inc(ia_q[head_q]) : 32'd0;
  assign ifq_count = reset ? '0 : cnt_q;

  assign push    = imem_req && imem_gnt;
  assign pop     = if_valid && if_ready;
  assign wr_fill = rsp_fill && !(byp && pop);

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
      outst_d = '0;
      drop_d  = OW'(inflight - (OW + 1)'(rsp_any));
    end else begin
      if (push) pc_d = pc_inc(pc_q);
      tail_d  = tail_q + PW'(push);
      head_d  = head_q + PW'(pop);
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      outst_d = outst_q + OW'(push) - OW'(rsp_fill);
      drop_d  = drop_q - OW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Slot payload carries no reset; occupancy is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (push) ia_q[tail_q] <= pc_q;
    if (wr_fill) instr_q[fill_idx] <= imem_rdata;
  end

endmodule
